// File: rtl/fpu_addsub_seq_ctrl.sv
// Sequencing controller for the floating-point add/subtract datapath.
// Optional build macro FPU_ADDSUB_AUTO_ACK_EN: DONE self-clears after one cycle and ack_i is ignored.
//
// state      | meaning
// IDLE       | datapath held in internal reset, waiting for start_i
// LOAD_OPER  | load operands
// ZERO_CHK   | zero operand short-circuits to DONE
// DIFF_EXP   | exponent difference
// SETTLE     | WAIT_CYC settle cycles before a shifter load, then jump to tgt
// NORM_SHIFT | alignment / normalisation shift
// ADD        | significand add
// OVF        | capture adder overflow, select exponent-B source
// EXP_OVF    | exponent adjust, counts normalisation passes
// ROUND_CHK  | decide whether a rounding increment is needed
// ADD_R      | rounding add
// OVF_R      | capture rounding overflow
// EXP_R      | exponent increment after rounding overflow
// SHIFT_R    | post-round right shift
// FINAL      | load result
// DONE       | result valid
module fpu_addsub_seq_ctrl #(
  parameter int WAIT_CYC = 1,
  parameter int MAX_NORM = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       ack_i,
  input  logic       zero_flag_i,
  input  logic       norm_iter_i,
  input  logic       add_ovf_i,
  input  logic       round_i,
  output logic       load_1_o,
  output logic       load_2_o,
  output logic       load_3_o,
  output logic       load_4_o,
  output logic       load_5_o,
  output logic       load_6_o,
  output logic       load_7_o,
  output logic       load_8_o,
  output logic       as_op_o,
  output logic       left_right_o,
  output logic       bit_shift_o,
  output logic       ctrl_a_o,
  output logic       ctrl_c_o,
  output logic       ctrl_d_o,
  output logic [1:0] ctrl_b_o,
  output logic       ctrl_b_load_o,
  output logic       rst_int_o,
  output logic       busy_o,
  output logic       ready_o,
  output logic       norm_err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_OPER, S_ZERO_CHK, S_DIFF_EXP, S_SETTLE, S_NORM_SHIFT,
    S_ADD, S_OVF, S_EXP_OVF, S_ROUND_CHK, S_ADD_R, S_OVF_R, S_EXP_R,
    S_SHIFT_R, S_FINAL, S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
  localparam logic [2:0] MAX_NORM_C  = 3'(MAX_NORM);

  state_t     state, state_nxt, tgt, tgt_nxt, branch, rule_st;
  logic [3:0] settle_cnt, settle_nxt;
  logic [2:0] pass_cnt, pass_nxt, pass_inc;
  logic       rnd_ph, rnd_ph_nxt, norm_err, norm_err_nxt, via_settle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tgt        <= S_IDLE;
      settle_cnt <= '0;
      pass_cnt   <= '0;
      rnd_ph     <= 1'b0;
      norm_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      tgt        <= tgt_nxt;
      settle_cnt <= settle_nxt;
      pass_cnt   <= pass_nxt;
      rnd_ph     <= rnd_ph_nxt;
      norm_err   <= norm_err_nxt;
    end
  end

  assign pass_inc = (pass_cnt == 3'd7) ? pass_cnt : pass_cnt + 3'd1;

  always_comb begin
    state_nxt    = state;
    tgt_nxt      = tgt;
    settle_nxt   = settle_cnt;
    pass_nxt     = pass_cnt;
    rnd_ph_nxt   = rnd_ph;
    norm_err_nxt = norm_err;
    branch       = S_IDLE;
    via_settle   = 1'b0;

    load_1_o      = 1'b0;
    load_2_o      = 1'b0;
    load_3_o      = 1'b0;
    load_4_o      = 1'b0;
    load_5_o      = 1'b0;
    load_6_o      = 1'b0;
    load_7_o      = 1'b0;
    load_8_o      = 1'b0;
    as_op_o       = 1'b1;
    left_right_o  = 1'b0;
    bit_shift_o   = 1'b0;
    ctrl_a_o      = rnd_ph;
    ctrl_c_o      = 1'b0;
    ctrl_d_o      = rnd_ph;
    ctrl_b_o      = 2'b00;
    ctrl_b_load_o = 1'b0;
    rst_int_o     = 1'b0;
    busy_o        = (state != S_IDLE) && (state != S_DONE);
    ready_o       = 1'b0;
    norm_err_o    = 1'b0;

    // SETTLE presents the shifter controls of the state it is about to enter
    rule_st = (state == S_SETTLE) ? tgt : state;
    if (rule_st == S_NORM_SHIFT && norm_iter_i) begin
      left_right_o = ~add_ovf_i;
      bit_shift_o  = add_ovf_i;
    end else if (rule_st == S_SHIFT_R) begin
      bit_shift_o  = add_ovf_i;
    end

    case (state)
      S_IDLE: begin
        rst_int_o    = 1'b1;
        pass_nxt     = '0;
        rnd_ph_nxt   = 1'b0;
        norm_err_nxt = 1'b0;
        if (start_i) state_nxt = S_LOAD_OPER;
      end
      S_LOAD_OPER: begin
        load_1_o  = 1'b1;
        state_nxt = S_ZERO_CHK;
      end
      S_ZERO_CHK: begin
        if (zero_flag_i) begin
          state_nxt = S_DONE;
        end else begin
          load_2_o  = 1'b1;
          state_nxt = S_DIFF_EXP;
        end
      end
      S_DIFF_EXP: begin
        load_3_o   = 1'b1;
        via_settle = 1'b1;
        branch     = S_NORM_SHIFT;
      end
      S_SETTLE: begin
        if (settle_cnt == 4'd0) state_nxt = tgt;
        else                    settle_nxt = settle_cnt - 4'd1;
      end
      S_NORM_SHIFT: begin
        load_4_o = 1'b1;
        if (norm_iter_i) begin
          state_nxt = S_ROUND_CHK;
        end else begin
          via_settle = 1'b1;
          branch     = S_ADD;
        end
      end
      S_ADD: begin
        load_5_o  = 1'b1;
        ctrl_c_o  = 1'b1;
        state_nxt = S_OVF;
      end
      S_OVF: begin
        load_6_o      = 1'b1;
        ctrl_b_load_o = 1'b1;
        ctrl_b_o      = add_ovf_i ? 2'b10 : 2'b01;
        state_nxt     = S_EXP_OVF;
      end
      S_EXP_OVF: begin
        load_3_o = 1'b1;
        load_8_o = 1'b1;
        as_op_o  = ~add_ovf_i;
        pass_nxt = pass_inc;
        if (pass_inc == MAX_NORM_C) begin
          norm_err_nxt = 1'b1;
          state_nxt    = S_FINAL;
        end else begin
          via_settle = 1'b1;
          branch     = S_NORM_SHIFT;
        end
      end
      S_ROUND_CHK: begin
        if (round_i) begin
          ctrl_a_o   = 1'b1;
          ctrl_d_o   = 1'b1;
          rnd_ph_nxt = 1'b1;
          via_settle = 1'b1;
          branch     = S_ADD_R;
        end else begin
          state_nxt = S_FINAL;
        end
      end
      S_ADD_R: begin
        load_5_o  = 1'b1;
        state_nxt = S_OVF_R;
      end
      S_OVF_R: begin
        load_6_o      = 1'b1;
        ctrl_b_load_o = 1'b1;
        ctrl_b_o      = add_ovf_i ? 2'b10 : 2'b11;
        if (add_ovf_i) begin
          state_nxt = S_EXP_R;
        end else begin
          via_settle = 1'b1;
          branch     = S_SHIFT_R;
        end
      end
      S_EXP_R: begin
        as_op_o    = 1'b0;
        load_3_o   = 1'b1;
        load_8_o   = 1'b1;
        via_settle = 1'b1;
        branch     = S_SHIFT_R;
      end
      S_SHIFT_R: begin
        load_4_o   = 1'b1;
        rnd_ph_nxt = 1'b0;
        state_nxt  = S_FINAL;
      end
      S_FINAL: begin
        load_7_o  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        ready_o    = 1'b1;
        norm_err_o = norm_err;
`ifdef FPU_ADDSUB_AUTO_ACK_EN
        state_nxt  = S_IDLE;
`else
        if (ack_i) state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase

    if (via_settle) begin
      if (WAIT_CYC == 0) begin
        state_nxt = branch;
      end else begin
        state_nxt  = S_SETTLE;
        tgt_nxt    = branch;
        settle_nxt = SETTLE_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_fpu_addsub_seq_ctrl.sv
// Bench for fpu_addsub_seq_ctrl: a per-operation sequence model builds the expected cycle trace,
// which is replayed against three parameter sets of the controller.
`timescale 1ns/1ps
module tb_fpu_addsub_seq_ctrl;

  typedef struct packed {
    logic start, ack, zero, norm_iter, ovf, rnd;
  } in_t;

  typedef struct packed {
    logic [8:1] load;
    logic       as_op, lr, bs, ca, cc, cd;
    logic [1:0] cb;
    logic       cbl, rsti, busy, ready, nerr;
  } out_t;

  localparam int NDUT = 3;

  function automatic int wc_of(int g);
    return (g == 0) ? 1 : (g == 1) ? 0 : 3;
  endfunction

  function automatic int mn_of(int g);
    return (g == 2) ? 3 : 2;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  din  [NDUT];
  out_t dout [NDUT];

  int vectors = 0;
  int miscompares = 0;

  in_t  tq [$];
  out_t eq [$];
  out_t obs [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [8:1] ld;
    logic as_op, lr, bs, ca, cc, cd, cbl, rsti, busy, ready, nerr;
    logic [1:0] cb;
    fpu_addsub_seq_ctrl #(.WAIT_CYC(wc_of(g)), .MAX_NORM(mn_of(g))) u_dut (
      .clk(clk), .rst(rst),
      .start_i(din[g].start), .ack_i(din[g].ack), .zero_flag_i(din[g].zero),
      .norm_iter_i(din[g].norm_iter), .add_ovf_i(din[g].ovf), .round_i(din[g].rnd),
      .load_1_o(ld[1]), .load_2_o(ld[2]), .load_3_o(ld[3]), .load_4_o(ld[4]),
      .load_5_o(ld[5]), .load_6_o(ld[6]), .load_7_o(ld[7]), .load_8_o(ld[8]),
      .as_op_o(as_op), .left_right_o(lr), .bit_shift_o(bs),
      .ctrl_a_o(ca), .ctrl_c_o(cc), .ctrl_d_o(cd), .ctrl_b_o(cb), .ctrl_b_load_o(cbl),
      .rst_int_o(rsti), .busy_o(busy), .ready_o(ready), .norm_err_o(nerr)
    );
    assign dout[g] = {ld, as_op, lr, bs, ca, cc, cd, cb, cbl, rsti, busy, ready, nerr};
  end

  function automatic out_t dflt(bit busy);
    out_t o;
    o = '0;
    o.as_op = 1'b1;
    o.busy = busy;
    return o;
  endfunction

  function automatic out_t idle_out();
    out_t o;
    o = dflt(0);
    o.rsti = 1'b1;
    return o;
  endfunction

  // Inputs the current step does not look at are randomised to prove they are ignored.
  task automatic push(in_t i, out_t o, bit hold);
    if (o.busy) begin
      i.start = 1'($urandom);
      i.ack = 1'($urandom);
      if (!hold) begin
        i.zero = 1'($urandom);
        i.rnd = 1'($urandom);
      end
    end
    tq.push_back(i);
    eq.push_back(o);
  endtask

  task automatic settle(int w, in_t i, bit lr, bit bs, bit r);
    out_t o;
    for (int c = 0; c < w; c++) begin
      o = dflt(1); o.lr = lr; o.bs = bs; o.ca = r; o.cd = r;
      push(i, o, 0);
    end
  endtask

  // One full operation starting from IDLE; norm_iter_i rises once k exponent passes are done.
  task automatic model_op(int g, bit zero, bit ovf_a, int k, bit rnd, bit ovf_r, int ack_dly);
    in_t i;
    out_t o;
    int w, mx, passes;
    bit err, ni, lr, bs, looping, to_round;
    w = wc_of(g); mx = mn_of(g); passes = 0; err = 0; to_round = 0; looping = 1;
    i = '0; i.ovf = ovf_a;
    i.start = 1; push(i, idle_out(), 1); i.start = 0;
    o = dflt(1); o.load[1] = 1; push(i, o, 0);
    i.zero = zero; o = dflt(1); o.load[2] = !zero; push(i, o, 1);
    if (!zero) begin
      o = dflt(1); o.load[3] = 1; push(i, o, 0);
      while (looping) begin
        ni = (passes >= k); i.norm_iter = ni;
        lr = ni && !ovf_a; bs = ni && ovf_a;
        settle(w, i, lr, bs, 0);
        o = dflt(1); o.load[4] = 1; o.lr = lr; o.bs = bs; push(i, o, 0);
        if (ni) begin
          to_round = 1; looping = 0;
        end else begin
          settle(w, i, 0, 0, 0);
          o = dflt(1); o.load[5] = 1; o.cc = 1; push(i, o, 0);
          o = dflt(1); o.load[6] = 1; o.cbl = 1; o.cb = ovf_a ? 2'b10 : 2'b01; push(i, o, 0);
          o = dflt(1); o.load[3] = 1; o.load[8] = 1; o.as_op = !ovf_a; push(i, o, 0);
          passes++;
          if (passes == mx) begin
            err = 1; looping = 0;
          end
        end
      end
      if (to_round) begin
        i.rnd = rnd; o = dflt(1); o.ca = rnd; o.cd = rnd; push(i, o, 1);
        if (rnd) begin
          i.ovf = ovf_r;
          settle(w, i, 0, 0, 1);
          o = dflt(1); o.load[5] = 1; o.ca = 1; o.cd = 1; push(i, o, 0);
          o = dflt(1); o.load[6] = 1; o.cbl = 1; o.cb = ovf_r ? 2'b10 : 2'b11;
          o.ca = 1; o.cd = 1; push(i, o, 0);
          if (ovf_r) begin
            o = dflt(1); o.as_op = 0; o.load[3] = 1; o.load[8] = 1; o.ca = 1; o.cd = 1;
            push(i, o, 0);
          end
          settle(w, i, 0, ovf_r, 1);
          o = dflt(1); o.load[4] = 1; o.bs = ovf_r; o.ca = 1; o.cd = 1; push(i, o, 0);
        end
      end
      o = dflt(1); o.load[7] = 1; push(i, o, 0);
    end
    o = dflt(0); o.ready = 1; o.nerr = err;
`ifdef FPU_ADDSUB_AUTO_ACK_EN
    i.ack = 1'($urandom); i.start = 1'($urandom); push(i, o, 1);
`else
    for (int c = 0; c < ack_dly; c++) begin
      i.ack = 0; i.start = 1'($urandom); push(i, o, 1);
    end
    i.ack = 1; i.start = 1'($urandom); push(i, o, 1);
`endif
    i = '0; push(i, idle_out(), 1);
  endtask

  task automatic replay(int g, int n, output int rdy_at, output int n4);
    rdy_at = -1; n4 = 0;
    for (int k = 0; k < n; k++) begin
      din[g] = tq[k];
      @(negedge clk);
      obs.push_back(dout[g]);
      if (dout[g].ready === 1'b1 && rdy_at < 0) rdy_at = k;
      if (dout[g].load[4] === 1'b1) n4++;
      @(posedge clk); #1;
    end
    din[g] = '0;
  endtask

  task automatic flush();
    tq.delete(); eq.delete(); obs.delete();
  endtask

  task automatic test_reset();
    for (int g = 0; g < NDUT; g++) begin
      vectors++;
      if (dout[g] !== idle_out()) begin
        miscompares++;
        $display("FAIL reset dut%0d: got %h expected %h", g, dout[g], idle_out());
      end
    end
  endtask

  task automatic test_zero_skip();
    int rdy, n4, n7;
    model_op(0, 1, 0, 0, 0, 0, 2);
    replay(0, tq.size(), rdy, n4);
    n7 = 0;
    foreach (eq[k]) begin
      vectors++;
      if (obs[k] !== eq[k]) begin
        miscompares++;
        $display("FAIL zero_skip step %0d: got %h expected %h", k, obs[k], eq[k]);
      end
      if (obs[k].load[7] === 1'b1) n7++;
    end
    vectors++;
    if (rdy !== 3) begin
      miscompares++;
      $display("FAIL zero_skip ready latency: got %0d expected 3", rdy);
    end
    vectors++;
    if (n7 !== 0) begin
      miscompares++;
      $display("FAIL zero_skip load_7 pulses: got %0d expected 0", n7);
    end
    flush();
  endtask

  task automatic test_norm_path();
    int rdy0, rdy1, n4_0, n4_1;
    model_op(1, 0, 0, 1, 0, 0, 3);
    replay(1, tq.size(), rdy0, n4_0);
    foreach (eq[k]) begin
      vectors++;
      if (obs[k] !== eq[k]) begin
        miscompares++;
        $display("FAIL norm_path_w0 step %0d: got %h expected %h", k, obs[k], eq[k]);
      end
    end
    flush();
    model_op(0, 0, 0, 1, 0, 0, 1);
    replay(0, tq.size(), rdy1, n4_1);
    foreach (eq[k]) begin
      vectors++;
      if (obs[k] !== eq[k]) begin
        miscompares++;
        $display("FAIL norm_path_w1 step %0d: got %h expected %h", k, obs[k], eq[k]);
      end
    end
    flush();
    vectors++;
    if (n4_0 !== 2) begin
      miscompares++;
      $display("FAIL norm_path load_4 pulses: got %0d expected 2", n4_0);
    end
    vectors++;
    if (rdy0 !== 11) begin
      miscompares++;
      $display("FAIL norm_path latency w0: got %0d expected 11", rdy0);
    end
    vectors++;
    if (rdy1 - rdy0 !== 3) begin
      miscompares++;
      $display("FAIL settle latency delta: got %0d expected 3", rdy1 - rdy0);
    end
  endtask

  task automatic test_norm_limit();
    int rdy, n4;
    model_op(1, 0, 1, 7, 0, 0, 1);
    model_op(1, 0, 0, 1, 0, 0, 0);
    replay(1, tq.size(), rdy, n4);
    foreach (eq[k]) begin
      vectors++;
      if (obs[k] !== eq[k]) begin
        miscompares++;
        $display("FAIL norm_limit step %0d: got %h expected %h", k, obs[k], eq[k]);
      end
    end
    flush();
  endtask

  task automatic test_round_ovf();
    int rdy, n4;
    model_op(0, 0, 0, 1, 1, 1, 1);
    model_op(2, 0, 1, 0, 1, 0, 0);
    replay(0, 0, rdy, n4);
    replay(2, tq.size() / 2, rdy, n4);
    flush();
    model_op(0, 0, 0, 1, 1, 1, 1);
    replay(0, tq.size(), rdy, n4);
    foreach (eq[k]) begin
      vectors++;
      if (obs[k] !== eq[k]) begin
        miscompares++;
        $display("FAIL round_ovf step %0d: got %h expected %h", k, obs[k], eq[k]);
      end
    end
    flush();
    model_op(2, 0, 1, 0, 1, 0, 2);
    replay(2, tq.size(), rdy, n4);
    foreach (eq[k]) begin
      vectors++;
      if (obs[k] !== eq[k]) begin
        miscompares++;
        $display("FAIL round_noovf step %0d: got %h expected %h", k, obs[k], eq[k]);
      end
    end
    flush();
  endtask

  task automatic test_back_to_back();
    int rdy, n4, n_ops;
    n_ops = 0;
    for (int r = 0; r < 4; r++) begin
      model_op(1, 1'(r == 2), 1'($urandom), r % 3, 1'($urandom), 1'($urandom), 0);
      tq[tq.size() - 2].start = 1'b1;
      n_ops++;
    end
    replay(1, tq.size(), rdy, n4);
    foreach (eq[k]) begin
      vectors++;
      if (obs[k] !== eq[k]) begin
        miscompares++;
        $display("FAIL back_to_back step %0d: got %h expected %h", k, obs[k], eq[k]);
      end
    end
    flush();
  endtask

  task automatic test_reset_mid_op();
    int idx, rdy, n4;
    model_op(0, 0, 0, 1, 0, 0, 0);
    idx = 0;
    while (idx < eq.size() && eq[idx].cc !== 1'b1) idx++;
    replay(0, idx, rdy, n4);
    din[0] = tq[idx];
    @(negedge clk);
    vectors++;
    if (dout[0] !== eq[idx]) begin
      miscompares++;
      $display("FAIL mid_op in ADD: got %h expected %h", dout[0], eq[idx]);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (dout[0] !== idle_out()) begin
      miscompares++;
      $display("FAIL async reset outputs: got %h expected %h", dout[0], idle_out());
    end
    din[0] = '0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (dout[0] !== idle_out()) begin
      miscompares++;
      $display("FAIL idle after reset: got %h expected %h", dout[0], idle_out());
    end
    flush();
    model_op(0, 0, 1, 1, 1, 0, 1);
    replay(0, tq.size(), rdy, n4);
    foreach (eq[k]) begin
      vectors++;
      if (obs[k] !== eq[k]) begin
        miscompares++;
        $display("FAIL post_reset step %0d: got %h expected %h", k, obs[k], eq[k]);
      end
    end
    flush();
  endtask

  task automatic test_random();
    int g, rdy, n4;
    for (int n = 0; n < 40; n++) begin
      g = int'($urandom_range(0, NDUT - 1));
      model_op(g, 1'($urandom_range(0, 5) == 0), 1'($urandom), int'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      replay(g, tq.size(), rdy, n4);
      foreach (eq[k]) begin
        vectors++;
        if (obs[k] !== eq[k]) begin
          miscompares++;
          $display("FAIL random op %0d dut%0d step %0d: got %h expected %h", n, g, k, obs[k], eq[k]);
        end
      end
      flush();
    end
  endtask

  initial begin
    for (int g = 0; g < NDUT; g++) din[g] = '0;
    #3;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_zero_skip();
    test_norm_path();
    test_norm_limit();
    test_round_ovf();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
